fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_W, default 8, instruction/data word width in bits.
REQ-002 Parameter ADDR_W, default 8, instruction address width in bits.
REQ-003 Parameter QDEPTH, default 4, prefetch queue entries; power of two and at least 2.
REQ-004 Parameter RESET_PC, default 0, fetch address loaded on reset.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 halt  input  1  when high, no new memory requests are issued.
REQ-008 redirect  input  1  pipeline flush with new fetch target (branch/jump/interrupt).
REQ-009 redirect_pc  input  ADDR_W  new fetch target, valid when redirect=1.
REQ-010 imem_req  output  1  instruction read request, combinational.
REQ-011 imem_addr  output  ADDR_W  request address; equals fetch_pc.
REQ-012 imem_data  input  DATA_W  read data, valid exactly one cycle after an accepted request.
REQ-013 ir_valid  output  1  queue head holds a valid instruction.
REQ-014 ir_ready  input  1  decode accepts the head instruction.
REQ-015 ir_data  output  DATA_W  head instruction word.
REQ-016 ir_pc  output  ADDR_W  address the head instruction was fetched from.
REQ-017 q_count  output  clog2(QDEPTH)+1  current queue occupancy.

Function
REQ-018 The memory accepts every cycle in which imem_req=1; there is no memory-side stall.
REQ-019 imem_req SHALL be 1 iff rst=1, redirect=0, halt=0, and (occupancy + in-flight) < QDEPTH.
REQ-020 On every edge with imem_req=1, fetch_pc SHALL advance by 1, modulo 2^ADDR_W: wrap from all-ones to 0.
REQ-021 On every edge with imem_req=1, an in-flight tag SHALL record the request address.
REQ-022 The response (imem_data and the tagged address) SHALL be written to the queue tail on the edge one cycle after the request.
REQ-023 Latency from request edge to ir_valid=1 SHALL be two edges.
REQ-024 Sustained throughput SHALL be one instruction per cycle while ir_ready=1 and halt=0.
REQ-025 A pop occurs on an edge with ir_valid=1 and ir_ready=1.
REQ-026 Push and pop on the same edge SHALL leave occupancy unchanged.
REQ-027 The queue SHALL never overflow, guaranteed by REQ-019.
REQ-028 The queue SHALL never underflow; ir_ready with ir_valid=0 has no effect.
REQ-029 ir_data and ir_pc SHALL be stable while ir_valid=1 and ir_ready=0.
REQ-030 Queue read and write pointers SHALL wrap modulo QDEPTH.
REQ-031 An edge with redirect=1 SHALL empty the queue, discard any in-flight response (no push next cycle), and load fetch_pc with redirect_pc.
REQ-032 Redirect SHALL take priority over a simultaneous push, pop or halt.
REQ-033 The first request after a redirect SHALL be issued in the cycle following the redirect edge, to address redirect_pc.
REQ-034 When halt=1, in-flight responses SHALL still be pushed, and the queue SHALL drain normally through pops.
REQ-035 When halt falls back to 0, fetching SHALL resume at the current fetch_pc with no lost or duplicated addresses.

Reset
REQ-036 While rst=0, all outputs and state SHALL take their reset values immediately, regardless of clk.
REQ-037 Reset values: fetch_pc=RESET_PC, occupancy=0, in-flight=0, ir_valid=0, ir_data=0, ir_pc=0, q_count=0.
REQ-038 imem_req SHALL be 0 while rst=0.
REQ-039 Reset asserted mid-operation SHALL discard queue contents and in-flight responses.
REQ-040 No push SHALL occur on the first edge after reset release.

Verification
REQ-041 Reset release, RESET_PC=0, ir_ready=1, memory returns data=addr+0x10 -> ir_pc 0,1,2,... with ir_data 0x10,0x11,... on consecutive cycles; first ir_valid two edges after first imem_req.
REQ-042 ir_ready=0 throughout, QDEPTH=4 -> exactly 4 requests issued (addresses 0..3); imem_req=0 afterwards; q_count=4; ir_pc=0 held stable.
REQ-043 Redirect to 0x40 while queue holds 3 entries and 1 request is in flight -> q_count=0 next edge; in-flight data never appears on ir_*; next requests 0x40,0x41; ir_pc=0x40 two edges after redirect.
REQ-044 fetch_pc=0xFE with ADDR_W=8 -> request addresses 0xFE, 0xFF, 0x00; ir_pc follows the same sequence.
REQ-045 halt=1 for 5 cycles with a request in flight and ir_ready=1 -> in-flight word delivered, then ir_valid=0; on release, requests resume at next sequential address.
REQ-046 rst pulsed low asynchronously between edges while queue is full -> ir_valid=0 and q_count=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: control inputs, instruction memory port and decode-side queue head.
// The fetch unit connects through the slave modport; its environment uses master.
interface fetch_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned QDEPTH = 4
);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic              halt;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              ir_valid;
  logic              ir_ready;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_pc;
  logic [CW-1:0]     q_count;

  modport slave (
    input  halt, redirect, redirect_pc, imem_data, ir_ready,
    output imem_req, imem_addr, ir_valid, ir_data, ir_pc, q_count
  );

  modport master (
    output halt, redirect, redirect_pc, imem_data, ir_ready,
    input  imem_req, imem_addr, ir_valid, ir_data, ir_pc, q_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, one-cycle-latency memory port, prefetch queue.
// Requests are throttled so queued plus in-flight words never exceed the queue depth.
module fetch_unit #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic   clk,
  input logic   rst,
  fetch_if.slave bus
);
  localparam int unsigned   PW    = $clog2(QDEPTH);
  localparam int unsigned   CW    = PW + 1;
  localparam logic [CW:0]   LIMIT = (CW+1)'(QDEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_tag;
  logic              r_inflight;
  logic [DATA_W-1:0] r_qdata [QDEPTH];
  logic [ADDR_W-1:0] r_qpc   [QDEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              w_req;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [CW:0]       w_pending;

  always_comb begin
    w_pending = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    w_valid   = (r_count != '0);
    w_req     = rst && !bus.redirect && !bus.halt && (w_pending < LIMIT);
    w_push    = r_inflight && !bus.redirect;
    w_pop     = w_valid && bus.ir_ready && !bus.redirect;
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.ir_valid  = w_valid;
  assign bus.q_count   = r_count;
  // Head is masked when empty so the outputs read zero after reset without clearing storage.
  assign bus.ir_data   = w_valid ? r_qdata[r_rptr] : '0;
  assign bus.ir_pc     = w_valid ? r_qpc[r_rptr]   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else if (bus.redirect) begin
      r_pc       <= bus.redirect_pc;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_tag <= r_pc;
        r_pc  <= r_pc + ADDR_W'(1);
      end
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qdata[r_wptr] <= bus.imem_data;
      r_qpc[r_wptr]   <= r_tag;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every falling edge,
// plus literal expectations at key points of each directed scenario.
module tb_fetch_unit;
  localparam int unsigned  DATA_W   = 8;
  localparam int unsigned  ADDR_W   = 8;
  localparam int unsigned  QDEPTH   = 4;
  localparam logic [7:0]   RESET_PC = 8'h00;

  logic clk;
  logic rst;

  fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) bus ();

  fetch_unit #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .QDEPTH  (QDEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: returns addr+0x10 in the cycle after each accepted request.
  logic [7:0] mem_addr;
  initial mem_addr = 8'h00;
  always @(posedge clk) if (bus.imem_req) mem_addr <= bus.imem_addr;
  assign bus.imem_data = mem_addr + 8'h10;

  int checks;
  int failures;
  bit done;

  logic [7:0] mq_pc[$];
  logic [7:0] mq_data[$];
  logic [7:0] m_pc;
  logic [7:0] m_tag;
  bit         m_inf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_and_step();
    int sz;
    bit exp_req;
    if (!rst) begin
      chk("rst_imem_req", bus.imem_req, 0);
      chk("rst_imem_addr", bus.imem_addr, RESET_PC);
      chk("rst_ir_valid", bus.ir_valid, 0);
      chk("rst_q_count", bus.q_count, 0);
      chk("rst_ir_data", bus.ir_data, 0);
      chk("rst_ir_pc", bus.ir_pc, 0);
      mq_pc.delete();
      mq_data.delete();
      m_pc  = RESET_PC;
      m_tag = 8'h00;
      m_inf = 1'b0;
    end else begin
      sz      = mq_pc.size();
      exp_req = !bus.redirect && !bus.halt && ((sz + int'(m_inf)) < QDEPTH);
      chk("imem_req", bus.imem_req, exp_req);
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("ir_valid", bus.ir_valid, sz != 0);
      chk("q_count", bus.q_count, sz);
      if (sz != 0) begin
        chk("ir_pc", bus.ir_pc, mq_pc[0]);
        chk("ir_data", bus.ir_data, mq_data[0]);
      end
      if (bus.redirect) begin
        mq_pc.delete();
        mq_data.delete();
        m_inf = 1'b0;
        m_pc  = bus.redirect_pc;
      end else begin
        if (sz != 0 && bus.ir_ready) begin
          void'(mq_pc.pop_front());
          void'(mq_data.pop_front());
        end
        if (m_inf) begin
          mq_pc.push_back(m_tag);
          mq_data.push_back(m_tag + 8'h10);
        end
        m_inf = exp_req;
        if (exp_req) begin
          m_tag = m_pc;
          m_pc  = m_pc + 8'h01;
        end
      end
    end
  endtask

  initial begin
    logic [15:0] pat_r;
    logic [15:0] pat_h;
    checks   = 0;
    failures = 0;
    done     = 1'b0;
    pat_r    = 16'hB2E5;
    pat_h    = 16'h0180;
    rst             = 1'b0;
    bus.halt        = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    bus.ir_ready    = 1'b1;

    fork
      begin
        while (!done) begin
          @(negedge clk);
          if (!done) compare_and_step();
        end
      end
      begin
        tick(); tick();

        // Reset release, streaming with ir_ready=1
        rst = 1'b1;
        #1;
        chk("rel_req", bus.imem_req, 1);
        chk("rel_addr", bus.imem_addr, 8'h00);
        chk("rel_valid", bus.ir_valid, 0);
        tick();
        chk("lat1_valid", bus.ir_valid, 0);
        chk("lat1_addr", bus.imem_addr, 8'h01);
        tick();
        chk("lat2_valid", bus.ir_valid, 1);
        chk("lat2_pc", bus.ir_pc, 8'h00);
        chk("lat2_data", bus.ir_data, 8'h10);
        tick();
        chk("seq_pc", bus.ir_pc, 8'h01);
        chk("seq_data", bus.ir_data, 8'h11);
        repeat (6) tick();

        // Back-pressure: queue fills to depth, requests stop
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h00;
        bus.ir_ready    = 1'b0;
        tick();
        bus.redirect = 1'b0;
        repeat (8) tick();
        chk("full_qcount", bus.q_count, 4);
        chk("full_req", bus.imem_req, 0);
        chk("full_irpc", bus.ir_pc, 8'h00);
        chk("full_addr", bus.imem_addr, 8'h04);

        // Redirect with 3 queued and 1 in flight
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        tick();
        chk("pre_redir_qcount", bus.q_count, 3);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h40;
        tick();
        bus.redirect = 1'b0;
        bus.ir_ready = 1'b1;
        #1;
        chk("redir_qcount", bus.q_count, 0);
        chk("redir_valid", bus.ir_valid, 0);
        chk("redir_req", bus.imem_req, 1);
        chk("redir_addr0", bus.imem_addr, 8'h40);
        tick();
        chk("redir_addr1", bus.imem_addr, 8'h41);
        chk("redir_valid1", bus.ir_valid, 0);
        tick();
        chk("redir_irpc", bus.ir_pc, 8'h40);
        chk("redir_irdata", bus.ir_data, 8'h50);
        repeat (3) tick();

        // Address wrap at 0xFF
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFE;
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("wrap_addr_fe", bus.imem_addr, 8'hFE);
        tick();
        chk("wrap_addr_ff", bus.imem_addr, 8'hFF);
        tick();
        chk("wrap_addr_00", bus.imem_addr, 8'h00);
        chk("wrap_pc_fe", bus.ir_pc, 8'hFE);
        chk("wrap_data_fe", bus.ir_data, 8'h0E);
        tick();
        chk("wrap_pc_ff", bus.ir_pc, 8'hFF);
        tick();
        chk("wrap_pc_00", bus.ir_pc, 8'h00);
        chk("wrap_data_00", bus.ir_data, 8'h10);
        repeat (3) tick();

        // Halt for 5 cycles while streaming
        bus.halt = 1'b1;
        repeat (5) tick();
        chk("halt_valid", bus.ir_valid, 0);
        chk("halt_qcount", bus.q_count, 0);
        bus.halt = 1'b0;
        #1;
        chk("resume_req", bus.imem_req, 1);
        repeat (6) tick();

        // Mixed ready/halt pattern
        for (int i = 0; i < 16; i++) begin
          bus.ir_ready = pat_r[i];
          bus.halt     = pat_h[i];
          tick();
        end
        bus.halt = 1'b0;

        // Asynchronous reset with a full queue
        bus.ir_ready = 1'b0;
        repeat (6) tick();
        chk("prerst_qcount", bus.q_count, 4);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", bus.ir_valid, 0);
        chk("async_qcount", bus.q_count, 0);
        chk("async_req", bus.imem_req, 0);
        chk("async_irdata", bus.ir_data, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("restart_addr", bus.imem_addr, RESET_PC);
        chk("restart_req", bus.imem_req, 1);
        bus.ir_ready = 1'b1;
        repeat (8) tick();

        done = 1'b1;
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
